spi_arb: RTL and testbench
==========================

Name: spi_arb

Overview:
- Shares one SPI master (monarch) transaction engine between two requesters: the inertial interface and the A2D interface.
- Each requester issues 16-bit command transactions. spi_arb buffers one pending command per requester and grants the master to one requester at a time.
- Inertial requests have priority. A starvation guard keeps the A2D from being locked out.
- Sits between inert_intf/A2D_intf and a single SPI master. sel steers SS_n/MISO routing at top level.

Parameters:
- STARVE_MAX, 4: max consecutive inertial grants issued while an A2D request is pending; the next grant is forced to A2D.
- GAP_CYC, 2: idle clocks after each transaction, before the next launch (guarantees SS_n deassert time).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- inert_req  in  1  one-cycle request pulse from inertial interface
- inert_cmd  in  16  command word, sampled with inert_req
- inert_done  out  1  one-cycle pulse: inertial transaction complete
- inert_rd  out  16  read data of last inertial transaction
- a2d_req  in  1  one-cycle request pulse from A2D interface
- a2d_cmd  in  16  command word, sampled with a2d_req
- a2d_done  out  1  one-cycle pulse: A2D transaction complete
- a2d_rd  out  16  read data of last A2D transaction
- mst_wrt  out  1  one-cycle launch strobe to SPI master
- mst_cmd  out  16  command to SPI master, held from launch until the end of GAP
- mst_done  in  1  SPI master completion pulse
- mst_rd  in  16  SPI master read data, valid with mst_done
- sel  out  1  current owner: 0 = inertial, 1 = A2D
- busy  out  1  high in LAUNCH, WAIT and GAP

Behaviour:
- Reset: every output is 0. Pending flags, latched commands, rd registers, starve_cnt and gap counter are cleared. State = IDLE.
- Request capture, per requester:
  - req high sets pend_x and latches cmd_x on that edge.
  - A req while pend_x is already set overwrites cmd_x (latest wins); there is still only one pending request.
  - A req during the requester's own in-flight transaction creates a new pending entry.
- FSM states: IDLE, LAUNCH, WAIT, GAP.
- IDLE:
  - If any pend_x is set, the next state is LAUNCH.
  - owner is chosen, sel and mst_cmd are loaded from cmd_owner, and pend_owner is cleared on that edge.
  - A req from the granted requester in that same cycle re-sets pend_x (set wins over clear).
- Arbitration when both are pending:
  - Inertial wins unless starve_cnt == STARVE_MAX, in which case A2D wins.
- starve_cnt:
  - Increments, saturating, on each inertial grant while pend_a2d is set.
  - Clears on every A2D grant.
  - Width is $clog2(STARVE_MAX+1).
- LAUNCH: mst_wrt = 1 for exactly this one cycle, then WAIT.
- WAIT:
  - On mst_done, mst_rd is registered into owner_rd.
  - owner_done pulses for one cycle on the following clock.
  - Next state is GAP.
  - mst_done seen in any other state is ignored.
- GAP: counts GAP_CYC clocks, then returns to IDLE. sel and mst_cmd stay stable from LAUNCH through the end of GAP.
- Latency, idle arbiter: req at cycle 0 -> pend at cycle 1 -> LAUNCH (mst_wrt high) at cycle 2.
- Latency, completion: mst_done at cycle n -> x_rd updated and x_done high at cycle n+1.
- Back-to-back: min spacing between mst_wrt pulses = transaction length + GAP_CYC + 2 clocks.
- inert_rd and a2d_rd hold their value until that requester's next completion.
- Simultaneous req_x and done_x for the same requester: both occur (new pending entry and done pulse).
- Reset mid-transaction: the transaction is abandoned, no done pulse is issued, and all pendings are lost.

Decomposition:
- Shared package seg_pkg holds:
  - typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, GAP} spi_arb_state_t
  - localparam OWN_INERT = 1'b0, OWN_A2D = 1'b1
- Sub-module req_slot: one-deep request buffer holding pend flag + 16-bit cmd, with set/clear priority. Instantiated twice.
- All other logic stays in spi_arb.

Test Plan:
- Single inertial request: inert_req with cmd 16'hA2B3 at cycle 0.
  - Required: mst_wrt at cycle 2 with mst_cmd = A2B3, sel = 0.
  - Model returns mst_done with rd 16'h1234 -> inert_rd = 1234 and inert_done pulses one cycle later; a2d_done stays 0.
- Simultaneous requests, inert_cmd 16'h0001 and a2d_cmd 16'h0002:
  - Required: inertial is served first, then A2D.
  - Second mst_wrt no earlier than GAP_CYC + 1 clocks after inert completion; sel = 1 for it.
- Starvation: A2D pending while inert_req is re-issued every transaction, STARVE_MAX = 4.
  - Required: exactly 4 inertial grants, then the A2D grant, then starve_cnt = 0.
- Overwrite: a2d_req with 16'h1111, then 16'h2222 before grant, while an inertial transaction is busy.
  - Required: a single A2D transaction with mst_cmd = 2222.
- Robustness:
  - Spurious mst_done in IDLE -> no done pulses and no rd change.
  - rst_n asserted during WAIT -> all outputs 0 immediately; no done pulse after release.
- Request during own transaction: inert_req while the inertial transaction is in WAIT.
  - Required: inert_done for the first transaction, then a second launch with the new command.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and owner encodings for the SPI master arbiter.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    GAP
  } spi_arb_state_t;

  localparam logic OWN_INERT = 1'b0;
  localparam logic OWN_A2D   = 1'b1;

endpackage

// File: rtl/spi_arb_req_slot.sv
// One-deep request buffer: pending flag plus latched 16-bit command.
// A set in the same cycle as a clear leaves the slot pending with the new command.
module req_slot (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        set,
  input  logic [15:0] set_cmd,
  input  logic        clr,
  output logic        pend,
  output logic [15:0] cmd
);

  logic        pend_q, pend_d;
  logic [15:0] cmd_q, cmd_d;

  // Next-state for the slot: clear first, then set overrides it.
  always_comb begin
    pend_d = pend_q;
    cmd_d  = cmd_q;
    if (clr) begin
      pend_d = 1'b0;
    end
    if (set) begin
      pend_d = 1'b1;
      cmd_d  = set_cmd;
    end
  end

  // Slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      cmd_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cmd_q  <= cmd_d;
    end
  end

  assign pend = pend_q;
  assign cmd  = cmd_q;

endmodule

// File: rtl/spi_arb.sv
// Arbitrates a single SPI master between the inertial and A2D interfaces.
// Inertial has priority; after STARVE_MAX consecutive inertial grants with an
// A2D request waiting, the next grant goes to A2D.
module spi_arb #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned GAP_CYC    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inert_req,
  input  logic [15:0] inert_cmd,
  output logic        inert_done,
  output logic [15:0] inert_rd,
  input  logic        a2d_req,
  input  logic [15:0] a2d_cmd,
  output logic        a2d_done,
  output logic [15:0] a2d_rd,
  output logic        mst_wrt,
  output logic [15:0] mst_cmd,
  input  logic        mst_done,
  input  logic [15:0] mst_rd,
  output logic        sel,
  output logic        busy
);

  import seg_pkg::*;

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);

  spi_arb_state_t state_q, state_d;
  logic           sel_q, sel_d;
  logic [15:0]    cmd_q, cmd_d;
  logic           wrt_q, wrt_d;
  logic           busy_q, busy_d;
  logic [SW-1:0]  starve_q, starve_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic           inert_done_q, inert_done_d;
  logic           a2d_done_q, a2d_done_d;
  logic [15:0]    inert_rd_q, inert_rd_d;
  logic [15:0]    a2d_rd_q, a2d_rd_d;

  logic           pend_inert, pend_a2d;
  logic [15:0]    slot_inert_cmd, slot_a2d_cmd;
  logic           clr_inert, clr_a2d;
  logic           owner;

  req_slot u_inert_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .set     (inert_req),
    .set_cmd (inert_cmd),
    .clr     (clr_inert),
    .pend    (pend_inert),
    .cmd     (slot_inert_cmd)
  );

  req_slot u_a2d_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .set     (a2d_req),
    .set_cmd (a2d_cmd),
    .clr     (clr_a2d),
    .pend    (pend_a2d),
    .cmd     (slot_a2d_cmd)
  );

  // Arbitration, transaction sequencing and result capture.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    cmd_d        = cmd_q;
    wrt_d        = 1'b0;
    starve_d     = starve_q;
    gap_d        = gap_q;
    inert_done_d = 1'b0;
    a2d_done_d   = 1'b0;
    inert_rd_d   = inert_rd_q;
    a2d_rd_d     = a2d_rd_q;
    clr_inert    = 1'b0;
    clr_a2d      = 1'b0;
    owner        = OWN_INERT;

    unique case (state_q)
      IDLE: begin
        if (pend_inert || pend_a2d) begin
          if (pend_inert && !(pend_a2d && (starve_q == STARVE_TOP))) begin
            owner = OWN_INERT;
          end else begin
            owner = OWN_A2D;
          end
          state_d = LAUNCH;
          sel_d   = owner;
          wrt_d   = 1'b1;
          if (owner == OWN_A2D) begin
            cmd_d    = slot_a2d_cmd;
            clr_a2d  = 1'b1;
            starve_d = '0;
          end else begin
            cmd_d     = slot_inert_cmd;
            clr_inert = 1'b1;
            if (pend_a2d && (starve_q != STARVE_TOP)) begin
              starve_d = starve_q + 1'b1;
            end
          end
        end
      end
      LAUNCH: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (mst_done) begin
          if (sel_q == OWN_A2D) begin
            a2d_rd_d   = mst_rd;
            a2d_done_d = 1'b1;
          end else begin
            inert_rd_d   = mst_rd;
            inert_done_d = 1'b1;
          end
          gap_d   = '0;
          state_d = (GAP_CYC == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_q        <= 1'b0;
      cmd_q        <= '0;
      wrt_q        <= 1'b0;
      busy_q       <= 1'b0;
      starve_q     <= '0;
      gap_q        <= '0;
      inert_done_q <= 1'b0;
      a2d_done_q   <= 1'b0;
      inert_rd_q   <= '0;
      a2d_rd_q     <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      cmd_q        <= cmd_d;
      wrt_q        <= wrt_d;
      busy_q       <= busy_d;
      starve_q     <= starve_d;
      gap_q        <= gap_d;
      inert_done_q <= inert_done_d;
      a2d_done_q   <= a2d_done_d;
      inert_rd_q   <= inert_rd_d;
      a2d_rd_q     <= a2d_rd_d;
    end
  end

  assign inert_done = inert_done_q;
  assign inert_rd   = inert_rd_q;
  assign a2d_done   = a2d_done_q;
  assign a2d_rd     = a2d_rd_q;
  assign mst_wrt    = wrt_q;
  assign mst_cmd    = cmd_q;
  assign sel        = sel_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_spi_arb.sv
// Bench for spi_arb: directed scenarios plus random traffic, all outputs
// compared every cycle against a cycle-counting transaction model.
module tb_spi_arb;

  localparam int unsigned STARVE_MAX = 4;
  localparam int unsigned GAP_CYC    = 2;

  logic        clk;
  logic        rst_n;
  logic        inert_req, a2d_req, mst_done;
  logic [15:0] inert_cmd, a2d_cmd, mst_rd;
  logic        inert_done, a2d_done, mst_wrt, sel, busy;
  logic [15:0] inert_rd, a2d_rd, mst_cmd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  spi_arb #(.STARVE_MAX(STARVE_MAX), .GAP_CYC(GAP_CYC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inert_req  (inert_req),
    .inert_cmd  (inert_cmd),
    .inert_done (inert_done),
    .inert_rd   (inert_rd),
    .a2d_req    (a2d_req),
    .a2d_cmd    (a2d_cmd),
    .a2d_done   (a2d_done),
    .a2d_rd     (a2d_rd),
    .mst_wrt    (mst_wrt),
    .mst_cmd    (mst_cmd),
    .mst_done   (mst_done),
    .mst_rd     (mst_rd),
    .sel        (sel),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: transaction bookkeeping by cycle number.
  bit          m_pend [2];
  logic [15:0] m_cmd  [2];
  logic [15:0] m_rd   [2];
  bit          e_done [2];
  int          m_starve;
  bit          m_fly;
  bit          m_own;
  int          m_launch;
  int          m_free;
  int          m_due;
  bit          m_sel;
  logic [15:0] m_mcmd;
  bit          e_wrt;

  bit          resp_fixed;
  logic [15:0] fixed_rd;

  // Observation log of launches and completions.
  int          l_cyc [$];
  bit          l_sel [$];
  logic [15:0] l_cmd [$];
  int          di_cyc [$];
  int          da_cyc [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 1'b0;
      m_cmd[i]  = '0;
      m_rd[i]   = '0;
      e_done[i] = 1'b0;
    end
    m_starve = 0;
    m_fly    = 1'b0;
    m_own    = 1'b0;
    m_launch = 0;
    m_free   = cyc;
    m_due    = 0;
    m_sel    = 1'b0;
    m_mcmd   = '0;
    e_wrt    = 1'b0;
  endfunction

  function automatic void clear_log();
    l_cyc.delete();
    l_sel.delete();
    l_cmd.delete();
    di_cyc.delete();
    da_cyc.delete();
  endfunction

  // One clock edge of the model: completion, then grant, then request capture.
  function automatic void model_edge(input bit ireq, input logic [15:0] icmd,
                                     input bit areq, input logic [15:0] acmd,
                                     input bit md, input logic [15:0] mrd);
    bit idle_before;
    bit g;
    idle_before = !m_fly && (cyc - 1 >= m_free);
    e_wrt     = 1'b0;
    e_done[0] = 1'b0;
    e_done[1] = 1'b0;
    if (m_fly && md && (cyc - 1 > m_launch)) begin
      m_rd[m_own]   = mrd;
      e_done[m_own] = 1'b1;
      m_fly         = 1'b0;
      m_free        = cyc + GAP_CYC;
    end
    if (idle_before && (m_pend[0] || m_pend[1])) begin
      g = m_pend[1] && (!m_pend[0] || (m_starve == STARVE_MAX));
      if (g) m_starve = 0;
      else if (m_pend[1] && (m_starve < STARVE_MAX)) m_starve++;
      m_own     = g;
      m_sel     = g;
      m_mcmd    = m_cmd[g];
      m_pend[g] = 1'b0;
      m_fly     = 1'b1;
      m_launch  = cyc;
      e_wrt     = 1'b1;
      m_due     = cyc + 2 + int'($urandom_range(0, 4));
    end
    if (ireq) begin m_pend[0] = 1'b1; m_cmd[0] = icmd; end
    if (areq) begin m_pend[1] = 1'b1; m_cmd[1] = acmd; end
  endfunction

  // Drive one cycle of inputs (master responder included), clock, then compare.
  task automatic step(input bit ireq, input logic [15:0] icmd,
                      input bit areq, input logic [15:0] acmd, input bit spur);
    bit          md;
    logic [15:0] mrd;
    md  = 1'b0;
    mrd = 16'($urandom);
    if (m_fly && (m_due == cyc + 1)) begin
      md = 1'b1;
      if (resp_fixed) mrd = fixed_rd;
    end else if (spur && !m_fly) begin
      md = 1'b1;
    end
    inert_req = ireq; inert_cmd = icmd;
    a2d_req   = areq; a2d_cmd   = acmd;
    mst_done  = md;   mst_rd    = mrd;
    @(posedge clk);
    #1;
    cyc++;
    model_edge(ireq, icmd, areq, acmd, md, mrd);
    chk("mst_wrt",    mst_wrt,    e_wrt);
    chk("mst_cmd",    mst_cmd,    m_mcmd);
    chk("sel",        sel,        m_sel);
    chk("busy",       busy,       (m_fly || (cyc < m_free)));
    chk("inert_done", inert_done, e_done[0]);
    chk("a2d_done",   a2d_done,   e_done[1]);
    chk("inert_rd",   inert_rd,   m_rd[0]);
    chk("a2d_rd",     a2d_rd,     m_rd[1]);
    if (mst_wrt) begin
      l_cyc.push_back(cyc);
      l_sel.push_back(sel);
      l_cmd.push_back(mst_cmd);
    end
    if (inert_done) di_cyc.push_back(cyc);
    if (a2d_done)   da_cyc.push_back(cyc);
    inert_req = 1'b0; a2d_req = 1'b0; mst_done = 1'b0;
  endtask

  task automatic run_idle(input string tag, input int bound);
    int n;
    n = 0;
    while ((m_fly || (cyc < m_free) || m_pend[0] || m_pend[1]) && (n < bound)) begin
      step(1'b0, '0, 1'b0, '0, 1'b0);
      n++;
    end
    chk(tag, (n < bound), 1'b1);
    step(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic wait_launch(input string tag, input int bound);
    int n;
    int prev;
    n    = 0;
    prev = l_cyc.size();
    while ((l_cyc.size() == prev) && (n < bound)) begin
      step(1'b0, '0, 1'b0, '0, 1'b0);
      n++;
    end
    chk(tag, (l_cyc.size() > prev), 1'b1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wrt"},   mst_wrt,    1'b0);
    chk({tag, "_cmd"},   mst_cmd,    16'h0);
    chk({tag, "_sel"},   sel,        1'b0);
    chk({tag, "_busy"},  busy,       1'b0);
    chk({tag, "_idone"}, inert_done, 1'b0);
    chk({tag, "_adone"}, a2d_done,   1'b0);
    chk({tag, "_ird"},   inert_rd,   16'h0);
    chk({tag, "_ard"},   a2d_rd,     16'h0);
  endtask

  initial begin
    int c0;
    int n;
    int prev;
    int n_inert;
    int n_a2d;
    bit reissue;
    bit a2d_seen;
    logic [15:0] a2d_cmd_seen;

    rst_n = 1'b0;
    inert_req = 1'b0; inert_cmd = '0;
    a2d_req   = 1'b0; a2d_cmd   = '0;
    mst_done  = 1'b0; mst_rd    = '0;
    resp_fixed = 1'b1;
    fixed_rd   = 16'h1234;

    // Reset state.
    @(posedge clk); #1;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc = 0;
    model_reset();
    clear_log();
    step(1'b0, '0, 1'b0, '0, 1'b0);

    // Single inertial request.
    clear_log();
    c0 = cyc;
    step(1'b1, 16'hA2B3, 1'b0, '0, 1'b0);
    run_idle("t1_settle", 60);
    chk("t1_launches", l_cyc.size(), 1);
    if (l_cyc.size() >= 1) begin
      chk("t1_launch_cyc", l_cyc[0], c0 + 2);
      chk("t1_cmd", l_cmd[0], 16'hA2B3);
      chk("t1_sel", l_sel[0], 1'b0);
    end
    chk("t1_inert_rd", inert_rd, 16'h1234);
    chk("t1_idone_cnt", di_cyc.size(), 1);
    chk("t1_adone_cnt", da_cyc.size(), 0);

    // Simultaneous requests: inertial first, then A2D after the gap.
    clear_log();
    fixed_rd = 16'h2468;
    step(1'b1, 16'h0001, 1'b1, 16'h0002, 1'b0);
    run_idle("t2_settle", 80);
    chk("t2_launches", l_cyc.size(), 2);
    if ((l_cyc.size() >= 2) && (di_cyc.size() >= 1)) begin
      chk("t2_first_sel", l_sel[0], 1'b0);
      chk("t2_first_cmd", l_cmd[0], 16'h0001);
      chk("t2_second_sel", l_sel[1], 1'b1);
      chk("t2_second_cmd", l_cmd[1], 16'h0002);
      chk("t2_spacing", (l_cyc[1] >= di_cyc[0] + int'(GAP_CYC) + 1), 1'b1);
    end

    // Starvation guard.
    clear_log();
    fixed_rd = 16'h0F0F;
    step(1'b1, 16'h0100, 1'b1, 16'hA0A0, 1'b0);
    reissue  = 1'b0;
    a2d_seen = 1'b0;
    n = 0;
    while (!a2d_seen && (n < 300)) begin
      prev = l_cyc.size();
      step(reissue, 16'(16'h0101 + n), 1'b0, '0, 1'b0);
      reissue = 1'b0;
      if (l_cyc.size() > prev) begin
        if (l_sel[l_cyc.size() - 1]) begin
          a2d_seen = 1'b1;
          chk("t3_starve_cleared", 32'(dut.starve_q), 0);
        end else begin
          reissue = 1'b1;
        end
      end
      n++;
    end
    chk("t3_a2d_granted", a2d_seen, 1'b1);
    n_inert = 0;
    a2d_cmd_seen = '0;
    for (int i = 0; i < l_sel.size(); i++) begin
      if (l_sel[i]) begin
        a2d_cmd_seen = l_cmd[i];
        break;
      end
      n_inert++;
    end
    chk("t3_inert_grants", n_inert, 4);
    chk("t3_a2d_cmd", a2d_cmd_seen, 16'hA0A0);
    run_idle("t3_settle", 80);

    // Overwrite of a pending A2D command while inertial is busy.
    clear_log();
    fixed_rd = 16'h2A2A;
    step(1'b1, 16'h3333, 1'b0, '0, 1'b0);
    wait_launch("t4_launch_seen", 10);
    step(1'b0, '0, 1'b1, 16'h1111, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1, 16'h2222, 1'b0);
    run_idle("t4_settle", 80);
    n_a2d = 0;
    a2d_cmd_seen = '0;
    for (int i = 0; i < l_sel.size(); i++) begin
      if (l_sel[i]) begin
        n_a2d++;
        a2d_cmd_seen = l_cmd[i];
      end
    end
    chk("t4_a2d_launches", n_a2d, 1);
    chk("t4_a2d_cmd", a2d_cmd_seen, 16'h2222);

    // Request from the requester whose transaction is in flight.
    clear_log();
    fixed_rd = 16'hBEEF;
    step(1'b1, 16'h5555, 1'b0, '0, 1'b0);
    wait_launch("t7_launch_seen", 10);
    step(1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b1, 16'h6666, 1'b0, '0, 1'b0);
    run_idle("t7_settle", 80);
    chk("t7_launches", l_cyc.size(), 2);
    chk("t7_idone_cnt", di_cyc.size(), 2);
    if ((l_cyc.size() >= 2) && (di_cyc.size() >= 1)) begin
      chk("t7_first_cmd", l_cmd[0], 16'h5555);
      chk("t7_second_cmd", l_cmd[1], 16'h6666);
      chk("t7_second_sel", l_sel[1], 1'b0);
      chk("t7_done_before_relaunch", (di_cyc[0] < l_cyc[1]), 1'b1);
    end

    // Spurious master completion while idle.
    clear_log();
    repeat (6) step(1'b0, '0, 1'b0, '0, 1'b1);
    chk("t5_idone_cnt", di_cyc.size(), 0);
    chk("t5_adone_cnt", da_cyc.size(), 0);
    chk("t5_inert_rd", inert_rd, 16'hBEEF);
    chk("t5_a2d_rd", a2d_rd, 16'h2A2A);

    // Reset asserted while waiting for the master.
    clear_log();
    step(1'b1, 16'h7777, 1'b1, 16'h8888, 1'b0);
    n = 0;
    while (!(m_fly && (cyc > m_launch)) && (n < 20)) begin
      step(1'b0, '0, 1'b0, '0, 1'b0);
      n++;
    end
    chk("t6_in_wait", (m_fly && (cyc > m_launch)), 1'b1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("t6_async");
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc = cyc + 2;
    rst_n = 1'b1;
    model_reset();
    clear_log();
    repeat (12) step(1'b0, '0, 1'b0, '0, 1'b0);
    chk("t6_no_idone", di_cyc.size(), 0);
    chk("t6_no_adone", da_cyc.size(), 0);
    chk("t6_no_launch", l_cyc.size(), 0);

    // Random traffic against the model.
    resp_fixed = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 7) == 0), 16'($urandom),
           ($urandom_range(0, 7) == 0), 16'($urandom),
           ($urandom_range(0, 15) == 0));
    end
    run_idle("rand_settle", 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
